// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state encoding and helpers for the ALU sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_ADD1  = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_SUB1  = 4'd4;
  localparam logic [3:0] OP_MUL   = 4'd5;
  localparam logic [3:0] OP_ROOF  = 4'd6;
  localparam logic [3:0] OP_FLOOR = 4'd7;
  localparam logic [3:0] OP_MOD   = 4'd8;

  // Wide enough for the WAIT down-counter at ALU_LAT=8.
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_e;

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_ROOF) || (op == OP_FLOOR) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_opchk.sv
// Combinational opcode classifier: illegal opcodes, and divide-by-zero when
// ALU_SEQ_DIVZERO_CHECK_EN is defined, both route the command to the error path.
module alu_seq_opchk
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
  input  logic [WIDTH-1:0] b,
`endif
  output logic             err
);

  logic legal;

  assign legal = (op >= OP_ADD) && (op <= OP_MOD);

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
  assign err = !legal || (op_is_div(op) && (b == '0));
`else
  assign err = !legal;
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Single-command sequencer driving a fixed-latency ALU and returning its result
// over a valid/ready handshake. Optional div-zero trap: ALU_SEQ_DIVZERO_CHECK_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1   // legal 1..8
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Cmd_valid,
  output logic             Cmd_ready,
  input  logic [3:0]       Cmd_op,
  input  logic [WIDTH-1:0] Cmd_a,
  input  logic [WIDTH-1:0] Cmd_b,
  output logic [WIDTH-1:0] In_1,
  output logic [WIDTH-1:0] In_2,
  output logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic             Z,
  input  logic             Y,
  output logic             Res_valid,
  input  logic             Res_ready,
  output logic [WIDTH-1:0] Res_data,
  output logic             Res_z,
  output logic             Res_y,
  output logic             Res_err
);

  // WAIT lasts ALU_LAT-1 cycles; the counter exits on zero, so load one less.
  localparam logic [CNT_W-1:0] WAIT_LOAD = (ALU_LAT > 1) ? CNT_W'(ALU_LAT - 2) : '0;

  seq_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       op_q;
  logic             cmd_err;
  logic             accept;

  alu_seq_opchk #(.WIDTH(WIDTH)) u_opchk (
    .op  (Cmd_op),
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    .b   (Cmd_b),
`endif
    .err (cmd_err)
  );

  assign Cmd_ready = (state == ST_IDLE);
  assign accept    = Cmd_valid && Cmd_ready;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      op_q     <= OP_NOP;
      ALUOp    <= OP_NOP;
      In_1     <= '0;
      In_2     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            In_1 <= Cmd_a;
            In_2 <= Cmd_b;
            op_q <= Cmd_op;
            if (cmd_err) begin
              state <= ST_DONE;
            end else begin
              ALUOp <= Cmd_op;
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          ALUOp <= OP_NOP;
          if (ALU_LAT > 1) begin
            wait_cnt <= WAIT_LOAD;
            state    <= ST_WAIT;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) state <= ST_CAPTURE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        ST_CAPTURE: state <= ST_DONE;
        ST_DONE: begin
          if (Res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result payload; ALU outputs are only looked at in CAPTURE.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Res_valid <= 1'b0;
      Res_data  <= '0;
      Res_z     <= 1'b0;
      Res_y     <= 1'b0;
      Res_err   <= 1'b0;
    end else begin
      if (state == ST_IDLE && accept && cmd_err) begin
        Res_valid <= 1'b1;
        Res_err   <= 1'b1;
        Res_data  <= '0;
        Res_z     <= 1'b0;
        Res_y     <= 1'b0;
      end else if (state == ST_CAPTURE) begin
        Res_valid <= 1'b1;
        Res_err   <= 1'b0;
        // The ALU leaves ALUOut stale on a SUB borrow, so report zero.
        Res_data  <= (op_q == OP_SUB && Y) ? '0 : ALUOut;
        Res_z     <= Z;
        Res_y     <= Y;
      end else if (state == ST_DONE && Res_ready) begin
        Res_valid <= 1'b0;
      end
    end
  end

endmodule
